fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch front end; sits directly upstream of Program_Memory and drives its Address_i.
- Holds the PC, computes the next PC (sequential, branch or jump), and captures Instruction_o from Program_Memory into an IF/ID pipeline register.
- Decode consumes the IF/ID register; decode also returns stall and redirect requests to this block.

Parameters:
- DATA_WIDTH, 32, width of PC, instruction and target buses.
- MEMORY_DEPTH, 32, number of words in Program_Memory; used only by the range check.
- RESET_PC, 32'h0040_0000, PC value loaded on reset (MIPS text base).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- Instruction_i  input  DATA_WIDTH  combinational read data from Program_Memory for Address_o.
- Stall_i  input  1  decode hazard; hold PC and IF/ID.
- Branch_Taken_i  input  1  redirect to Branch_Target_i.
- Branch_Target_i  input  DATA_WIDTH  branch destination byte address.
- Jump_i  input  1  redirect to Jump_Target_i.
- Jump_Target_i  input  DATA_WIDTH  jump destination byte address.
- Address_o  output  DATA_WIDTH  current PC, wired to Program_Memory Address_i.
- IFID_Instruction_o  output  DATA_WIDTH  registered instruction.
- IFID_PC_Plus4_o  output  DATA_WIDTH  registered PC+4 of that instruction.
- IFID_Valid_o  output  1  IF/ID holds a real instruction.
- Fetch_Count_o  output  32  count of instructions loaded into IF/ID.

Behaviour:
- Reset values:
  - PC = RESET_PC.
  - IFID_Instruction_o = 0 (NOP).
  - IFID_PC_Plus4_o = 0.
  - IFID_Valid_o = 0.
  - Fetch_Count_o = 0.
  - FSM = BOOT.
- FSM states: BOOT, FETCH, HOLD.
  - BOOT: one cycle after reset. IF/ID stays invalid and PC holds, so Program_Memory sees a full cycle on RESET_PC. Next state is FETCH unconditionally.
  - FETCH, per rising edge, priority reset > redirect > stall > advance:
    - Redirect (Jump_i or Branch_Taken_i): PC <= target with bits[1:0] forced to 0. Jump_Target_i wins if both are asserted. IF/ID is flushed (instruction 0, Valid 0). No delay slot.
    - Stall (no redirect): PC, IF/ID and counter hold. Next state is HOLD.
    - Advance: IF/ID <= {Instruction_i, PC+4, 1}; PC <= PC+4; Fetch_Count_o += 1.
  - HOLD: same rules as FETCH. Returns to FETCH on the first cycle with Stall_i low.
    - A redirect in HOLD is taken immediately and clears the stall path.
- Latency: the instruction at address A appears on IFID_* one clock after Address_o = A.
- Arithmetic:
  - PC+4 is modulo 2^DATA_WIDTH; 32'hFFFF_FFFC wraps to 0 with no flag.
  - Fetch_Count_o wraps 32'hFFFF_FFFF to 0.
- Reset mid-stall or mid-redirect: reset wins, returns to BOOT with all reset values.
- Address_o is PC directly; no combinational path from Stall_i or redirect inputs to Address_o.

Optional Feature:
- Macro: FETCH_RANGE_CHECK_EN.
- With the macro defined:
  - Adds output Fetch_Fault_o (1 bit, reset 0) and state FAULT.
  - The range check runs in FETCH: a PC outside [RESET_PC, RESET_PC + 4*MEMORY_DEPTH) inserts a bubble (Valid 0) instead of loading IF/ID.
  - On that fault: Fetch_Fault_o is set, PC freezes, next state is FAULT.
  - FAULT exits only on a redirect (fault cleared, target loaded) or on reset.
- Without the macro: no port and no state; any PC is fetched unchecked.

Decomposition:
- Package fetch_pkg holds:
  - RESET_PC default.
  - NOP_INSTR = 32'h0000_0000.
  - PC_INCR = 4.
  - Enumerated fetch_state_t {BOOT, FETCH, HOLD, FAULT}.
- One natural sub-module, pc_register: DATA_WIDTH register with synchronous reset to RESET_PC and a load enable. Instantiated once for the PC.
- The IF/ID register and FSM stay inline.

Test Plan:
- Reset, then run 4 cycles with Instruction_i = 32'h2008_0005 → Address_o shows 0x400000 (BOOT), 0x400000, 0x400004, 0x400008. Valid goes 0,0,1,1. IFID_PC_Plus4_o = 0x400004 then 0x400008. Fetch_Count_o = 2.
- Stall_i high for 3 cycles at PC 0x400008 → Address_o, IFID_* and count are frozen. On release, PC goes to 0x40000C the next edge.
- Branch_Taken_i with target 0x400022 at PC 0x40000C → PC = 0x400020, IF/ID Valid 0, count unchanged. Jump_i and Branch_Taken_i together with jump target 0x400040 → PC = 0x400040.
- Redirect asserted during a stall → redirect taken the same edge; FSM leaves HOLD; next cycle fetches the target.
- Reset asserted mid-stall at PC 0x400010 → next edge PC = 0x400000, all outputs at reset values, FSM = BOOT.
- With FETCH_RANGE_CHECK_EN and MEMORY_DEPTH = 32: advance to PC 0x400080 → Fetch_Fault_o = 1, Valid 0, PC held. Then Jump_i to 0x400000 → fault cleared, fetch resumes.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch front end.
// FETCH_RANGE_CHECK_EN adds the FAULT state used by the optional PC range check.
package fetch_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam int unsigned PC_INCR          = 4;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HOLD
`ifdef FETCH_RANGE_CHECK_EN
    , FAULT
`endif
  } fetch_state_t;
endpackage

// File: rtl/fetch_stage_pc_register.sv
// Program counter register: synchronous reset to RESET_PC, updates only when load is high.
module pc_register
  import fetch_pkg::*;
#(
  parameter int unsigned     DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset)     q <= RESET_PC;
    else if (load) q <= d;
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC, next-PC selection, IF/ID register and fetch FSM.
// Define FETCH_RANGE_CHECK_EN to add the PC range check, Fetch_Fault_o and the FAULT state.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] Instruction_i,
  input  logic                  Stall_i,
  input  logic                  Branch_Taken_i,
  input  logic [DATA_WIDTH-1:0] Branch_Target_i,
  input  logic                  Jump_i,
  input  logic [DATA_WIDTH-1:0] Jump_Target_i,
  output logic [DATA_WIDTH-1:0] Address_o,
  output logic [DATA_WIDTH-1:0] IFID_Instruction_o,
  output logic [DATA_WIDTH-1:0] IFID_PC_Plus4_o,
  output logic                  IFID_Valid_o,
`ifdef FETCH_RANGE_CHECK_EN
  output logic                  Fetch_Fault_o,
`endif
  output logic [31:0]           Fetch_Count_o
);
  fetch_state_t state, next_state;

  logic [DATA_WIDTH-1:0] pc, pc_next, pc_plus4, redirect_pc, target;
  logic                  pc_load, ifid_load, ifid_flush, redirect;

  assign pc_plus4    = pc + DATA_WIDTH'(PC_INCR);
  assign redirect    = Jump_i | Branch_Taken_i;
  assign target      = Jump_i ? Jump_Target_i : Branch_Target_i;
  assign redirect_pc = {target[DATA_WIDTH-1:2], 2'b00};
  assign Address_o   = pc;

`ifdef FETCH_RANGE_CHECK_EN
  localparam logic [DATA_WIDTH-1:0] SPAN = DATA_WIDTH'(PC_INCR * MEMORY_DEPTH);
  logic [DATA_WIDTH-1:0] pc_offset;
  logic                  pc_in_range, fault_set, fault_clr;
  // Offset from the text base: anything below RESET_PC wraps to a huge value.
  assign pc_offset   = pc - RESET_PC;
  assign pc_in_range = pc_offset < SPAN;
`endif

  pc_register #(
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc (
    .clk   (clk),
    .reset (reset),
    .load  (pc_load),
    .d     (pc_next),
    .q     (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= BOOT;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    pc_load    = 1'b0;
    pc_next    = pc;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
`ifdef FETCH_RANGE_CHECK_EN
    fault_set  = 1'b0;
    fault_clr  = 1'b0;
`endif
    case (state)
      BOOT: next_state = FETCH;
      FETCH, HOLD: begin
        if (redirect) begin
          pc_load    = 1'b1;
          pc_next    = redirect_pc;
          ifid_flush = 1'b1;
          next_state = FETCH;
        end else if (Stall_i) begin
          next_state = HOLD;
`ifdef FETCH_RANGE_CHECK_EN
        end else if (!pc_in_range) begin
          ifid_flush = 1'b1;
          fault_set  = 1'b1;
          next_state = FAULT;
`endif
        end else begin
          pc_load    = 1'b1;
          pc_next    = pc_plus4;
          ifid_load  = 1'b1;
          next_state = FETCH;
        end
      end
`ifdef FETCH_RANGE_CHECK_EN
      FAULT: begin
        if (redirect) begin
          pc_load    = 1'b1;
          pc_next    = redirect_pc;
          ifid_flush = 1'b1;
          fault_clr  = 1'b1;
          next_state = FETCH;
        end
      end
`endif
      default: next_state = BOOT;
    endcase
  end

  // IF/ID register and fetch counter
  always_ff @(posedge clk) begin
    if (reset) begin
      IFID_Instruction_o <= DATA_WIDTH'(NOP_INSTR);
      IFID_PC_Plus4_o    <= '0;
      IFID_Valid_o       <= 1'b0;
      Fetch_Count_o      <= '0;
    end else if (ifid_flush) begin
      IFID_Instruction_o <= DATA_WIDTH'(NOP_INSTR);
      IFID_Valid_o       <= 1'b0;
    end else if (ifid_load) begin
      IFID_Instruction_o <= Instruction_i;
      IFID_PC_Plus4_o    <= pc_plus4;
      IFID_Valid_o       <= 1'b1;
      Fetch_Count_o      <= Fetch_Count_o + 32'd1;
    end
  end

`ifdef FETCH_RANGE_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset)          Fetch_Fault_o <= 1'b0;
    else if (fault_set) Fetch_Fault_o <= 1'b1;
    else if (fault_clr) Fetch_Fault_o <= 1'b0;
  end
`endif
endmodule
